// File: rtl/inst_fetch_if.sv
// Byte-wide instruction memory bus between the fetch unit (master) and the memory controller (slave).
interface inst_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        mem_valid;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_valid);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_valid);
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: assembles 32-bit little-endian words from a byte bus, with stall hold and jump redirect.
// Optional feature: define ICACHE_EN for a 64-entry direct-mapped instruction cache.
module inst_fetch (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         jump_en,
    input  logic [31:0]  jump_addr,
    inst_fetch_if.master mem,
    output logic [31:0]  pc_o,
    output logic [31:0]  inst_o,
    output logic         inst_valid
);
    typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic [1:0]  r_cnt, w_cnt_next;
    logic [23:0] r_buf, w_buf_next;
    logic [31:0] r_hold_word, w_hold_word_next;
    logic [31:0] r_pc_o, w_pc_o_next;
    logic [31:0] r_inst_o, w_inst_o_next;
    logic        r_inst_valid, w_inst_valid_next;
    logic        r_run;
    logic        w_fetch, w_hit, w_mem_req, w_avail;
    logic [31:0] w_word, w_cache_word, w_avail_word;

    // r_run keeps the bus quiet until the first edge that samples rst low.
    assign w_fetch   = r_run && (r_state == FETCH);
    assign w_word    = {mem.mem_rdata, r_buf};
    assign w_mem_req = w_fetch && !w_hit;

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = r_run ? (r_pc + {30'd0, r_cnt}) : 32'd0;
    assign pc_o         = r_pc_o;
    assign inst_o       = r_inst_o;
    assign inst_valid   = r_inst_valid;

`ifdef ICACHE_EN
    logic [31:0] r_cache_data [0:63];
    logic [23:0] r_cache_tag  [0:63];
    logic [63:0] r_cache_valid;
    logic [5:0]  w_idx;
    logic        w_cache_wr;

    // Lookup must resolve within the cycle so a hit can issue at the same edge.
    assign w_idx        = r_pc[7:2];
    assign w_hit        = w_fetch && (r_cnt == 2'd0) && r_cache_valid[w_idx]
                          && (r_cache_tag[w_idx] == r_pc[31:8]);
    assign w_cache_word = r_cache_data[w_idx];
    assign w_cache_wr   = w_mem_req && mem.mem_valid && (r_cnt == 2'd3) && !jump_en;

    always_ff @(posedge clk) begin
        if (w_cache_wr) begin
            r_cache_data[w_idx] <= w_word;
            r_cache_tag[w_idx]  <= r_pc[31:8];
        end
    end

    generate
        for (genvar gi = 0; gi < 64; gi++) begin : g_valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cache_valid[gi] <= 1'b0;
                end else if (w_cache_wr && (w_idx == gi[5:0])) begin
                    r_cache_valid[gi] <= 1'b1;
                end
            end
        end
    endgenerate
`else
    assign w_hit        = 1'b0;
    assign w_cache_word = 32'd0;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_cnt_next        = r_cnt;
        w_buf_next        = r_buf;
        w_hold_word_next  = r_hold_word;
        w_pc_o_next       = r_pc_o;
        w_inst_o_next     = r_inst_o;
        w_inst_valid_next = 1'b0;
        w_avail           = 1'b0;
        w_avail_word      = w_word;

        if (w_hit) begin
            w_avail      = 1'b1;
            w_avail_word = w_cache_word;
        end else if (w_mem_req && mem.mem_valid) begin
            if (r_cnt == 2'd3) begin
                w_avail = 1'b1;
            end else begin
                case (r_cnt)
                    2'd0:    w_buf_next[7:0]   = mem.mem_rdata;
                    2'd1:    w_buf_next[15:8]  = mem.mem_rdata;
                    default: w_buf_next[23:16] = mem.mem_rdata;
                endcase
                w_cnt_next = r_cnt + 2'd1;
            end
        end else if (r_state == HOLD && !stall) begin
            w_avail      = 1'b1;
            w_avail_word = r_hold_word;
        end

        // A complete word either issues now or parks in the hold register.
        if (w_avail) begin
            w_cnt_next = 2'd0;
            if (stall) begin
                w_hold_word_next = w_avail_word;
                w_state_next     = HOLD;
            end else begin
                w_pc_o_next       = r_pc;
                w_inst_o_next     = w_avail_word;
                w_inst_valid_next = 1'b1;
                w_pc_next         = r_pc + 32'd4;
                w_state_next      = FETCH;
            end
        end

        if (jump_en) begin
            w_pc_next         = jump_addr & 32'hFFFF_FFFC;
            w_cnt_next        = 2'd0;
            w_buf_next        = 24'd0;
            w_state_next      = FETCH;
            w_inst_valid_next = 1'b0;
            w_pc_o_next       = r_pc_o;
            w_inst_o_next     = r_inst_o;
            w_hold_word_next  = r_hold_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FETCH;
            r_pc         <= 32'd0;
            r_cnt        <= 2'd0;
            r_buf        <= 24'd0;
            r_hold_word  <= 32'd0;
            r_pc_o       <= 32'd0;
            r_inst_o     <= 32'd0;
            r_inst_valid <= 1'b0;
            r_run        <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_cnt        <= w_cnt_next;
            r_buf        <= w_buf_next;
            r_hold_word  <= w_hold_word_next;
            r_pc_o       <= w_pc_o_next;
            r_inst_o     <= w_inst_o_next;
            r_inst_valid <= w_inst_valid_next;
            r_run        <= 1'b1;
        end
    end
endmodule
